// File: rtl/wfifo_wr_arbiter_if.sv
// Write-port bundle between the requesters/FIFO and the write arbiter.
// The arbiter takes the master side; the environment (producers + FIFO) takes the slave side.
interface wfifo_wr_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8
);
  localparam int unsigned IdW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  gnt_valid;
  logic [IdW-1:0]        gnt_id;

  modport master (
    input  req_valid,
    input  req_data,
    input  wfull,
    output req_ready,
    output winc,
    output wdata,
    output gnt_valid,
    output gnt_id
  );

  modport slave (
    output req_valid,
    output req_data,
    output wfull,
    input  req_ready,
    input  winc,
    input  wdata,
    input  gnt_valid,
    input  gnt_id
  );
endinterface

// File: rtl/wfifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing the async FIFO write port among NREQ
// write-domain requesters. One ARB bubble cycle precedes every burst.
module wfifo_wr_arbiter #(
  parameter int unsigned NREQ     = 4,  // 2..8
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned MAXBURST = 4   // 1..16
) (
  input logic                wclk,
  input logic                wrst_n,
  wfifo_wr_arbiter_if.master bus
);
  localparam int unsigned IdW   = $clog2(NREQ);
  localparam int unsigned BeatW = $clog2(MAXBURST + 1);

  typedef enum logic {StArb, StBurst} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     last_gnt_q, last_gnt_d;
  logic [IdW-1:0]     gnt_id_q, gnt_id_d;
  logic [BeatW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IdW-1:0]     pick;
  logic [IdW-1:0]     idx;
  logic               gnt_req_valid;
  logic               xfer;
  logic               winc;
  logic [NREQ-1:0]    req_ready;
  logic [DSIZE-1:0]   wdata;

  // Round-robin pick: scan from farthest to nearest so the first valid after last_gnt wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      idx = IdW'((int'(last_gnt_q) + k) % int'(NREQ));
      if (bus.req_valid[idx]) begin
        pick = idx;
      end
    end
  end

  // Write-port datapath: strobe and ready are gated by wfull so no write is attempted while full.
  always_comb begin
    gnt_req_valid = bus.req_valid[gnt_id_q];
    xfer          = (state_q == StBurst) && gnt_req_valid && !bus.wfull;
    winc          = xfer;
    req_ready     = '0;
    wdata         = '0;
    if (state_q == StBurst) begin
      req_ready[gnt_id_q] = ~bus.wfull;
      wdata               = bus.req_data[int'(gnt_id_q) * int'(DSIZE) +: DSIZE];
    end
  end

  // Next-state: grant in ARB, count beats in BURST, leave on last beat or on dropped valid.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StArb: begin
        if (|bus.req_valid) begin
          gnt_id_d   = pick;
          last_gnt_d = pick;
          beat_cnt_d = '0;
          state_d    = StBurst;
        end
      end
      StBurst: begin
        if (!gnt_req_valid) begin
          // Dropping valid ends the burst even while the FIFO is full.
          state_d = StArb;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + BeatW'(1);
          if (beat_cnt_q == BeatW'(MAXBURST - 1)) begin
            state_d = StArb;
          end
        end
      end
    endcase
  end

  // State registers; reset biases the first grant toward requester 0.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= StArb;
      last_gnt_q <= IdW'(NREQ - 1);
      gnt_id_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.winc      = winc;
  assign bus.req_ready = req_ready;
  assign bus.wdata     = wdata;
  assign bus.gnt_valid = (state_q == StBurst);
  assign bus.gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_wfifo_wr_arbiter.sv
// Bench for wfifo_wr_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the grant rules.
module tb_wfifo_wr_arbiter;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned DSIZE    = 8;
  localparam int unsigned MAXBURST = 4;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wfifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  wfifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic set_data(input int i, input logic [DSIZE-1:0] v);
    bus.req_data[i*DSIZE +: DSIZE] = v;
  endtask

  // Leaves the bench at posedge+1 of the first post-reset cycle (ARB).
  task automatic do_reset();
    wrst_n        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;
    @(posedge wclk); #1;
    @(posedge wclk); #1;
    wrst_n = 1'b1;
  endtask

  task automatic test_reset();
    wrst_n        = 1'b0;
    bus.req_valid = '1;
    bus.req_data  = '1;
    bus.wfull     = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(negedge wclk);
      checks++; if (bus.winc !== 1'b0) begin errors++; $display("FAIL reset_winc got %b want 0", bus.winc); end
      checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
      checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid got %b want 0", bus.gnt_valid); end
      checks++; if (bus.wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", bus.wdata); end
      checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got %0d want 0", bus.gnt_id); end
    end
  endtask

  task automatic test_single_stream();
    logic [9:0] exp_winc = 10'b0011011110;
    logic [9:0] exp_gv   = 10'b0111011110;
    int n = 0;
    logic hs;
    do_reset();
    bus.req_valid = 4'b0010;
    set_data(1, 8'h10);
    for (int c = 0; c < 10; c++) begin
      @(negedge wclk);
      checks++; if (bus.winc !== exp_winc[c]) begin errors++; $display("FAIL single_winc c%0d got %b want %b", c, bus.winc, exp_winc[c]); end
      checks++; if (bus.gnt_valid !== exp_gv[c]) begin errors++; $display("FAIL single_gv c%0d got %b want %b", c, bus.gnt_valid, exp_gv[c]); end
      if (c >= 1) begin
        checks++; if (bus.gnt_id !== 2'd1) begin errors++; $display("FAIL single_gnt_id c%0d got %0d want 1", c, bus.gnt_id); end
      end
      if (exp_winc[c]) begin
        checks++; if (bus.wdata !== 8'(16 + n)) begin errors++; $display("FAIL single_wdata c%0d got %h want %h", c, bus.wdata, 8'(16 + n)); end
      end
      hs = bus.req_valid[1] & bus.req_ready[1];
      @(posedge wclk); #1;
      if (hs) begin
        n++;
        set_data(1, 8'(16 + n));
        if (n == 6) bus.req_valid = 4'b0000;
      end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL single_count got %0d want 6", n); end
  endtask

  task automatic test_all_requesting();
    int cnt[NREQ];
    int words = 0;
    int exp_id;
    logic exp_w;
    logic [NREQ-1:0] hs;
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      cnt[i] = 0;
      set_data(i, 8'(i * 16));
    end
    bus.req_valid = '1;
    for (int c = 0; c < 25; c++) begin
      @(negedge wclk);
      exp_w = (c % 5) != 0;
      checks++; if (bus.winc !== exp_w) begin errors++; $display("FAIL all_winc c%0d got %b want %b", c, bus.winc, exp_w); end
      checks++; if (bus.gnt_valid !== exp_w) begin errors++; $display("FAIL all_gv c%0d got %b want %b", c, bus.gnt_valid, exp_w); end
      if (exp_w) begin
        exp_id = ((c - 1) / 5) % 4;
        checks++; if (bus.gnt_id !== 2'(exp_id)) begin errors++; $display("FAIL all_gnt_id c%0d got %0d want %0d", c, bus.gnt_id, exp_id); end
        checks++; if (bus.req_ready !== 4'(1 << exp_id)) begin errors++; $display("FAIL all_ready c%0d got %b want %b", c, bus.req_ready, 4'(1 << exp_id)); end
        checks++; if (bus.wdata !== 8'(exp_id * 16 + cnt[exp_id])) begin errors++; $display("FAIL all_wdata c%0d got %h want %h", c, bus.wdata, 8'(exp_id * 16 + cnt[exp_id])); end
      end
      if (bus.winc === 1'b1) words++;
      hs = bus.req_valid & bus.req_ready;
      @(posedge wclk); #1;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (hs[i]) begin
          cnt[i]++;
          set_data(i, 8'(i * 16 + cnt[i]));
        end
      end
    end
    checks++; if (words != 20) begin errors++; $display("FAIL all_words got %0d want 20", words); end
    bus.req_valid = '0;
  endtask

  task automatic test_wfull_mid_burst();
    int n = 0;
    logic exp_w, exp_gv;
    logic hs;
    do_reset();
    bus.req_valid = 4'b0100;
    set_data(2, 8'h20);
    for (int c = 0; c < 9; c++) begin
      bus.wfull = (c >= 3 && c <= 5);
      @(negedge wclk);
      exp_w  = (c == 1 || c == 2 || c == 6 || c == 7);
      exp_gv = (c >= 1 && c <= 7);
      checks++; if (bus.winc !== exp_w) begin errors++; $display("FAIL full_winc c%0d got %b want %b", c, bus.winc, exp_w); end
      checks++; if (bus.gnt_valid !== exp_gv) begin errors++; $display("FAIL full_gv c%0d got %b want %b", c, bus.gnt_valid, exp_gv); end
      if (c >= 1) begin
        checks++; if (bus.gnt_id !== 2'd2) begin errors++; $display("FAIL full_gnt_id c%0d got %0d want 2", c, bus.gnt_id); end
      end
      if (c >= 3 && c <= 5) begin
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL full_ready c%0d got %b want 0000", c, bus.req_ready); end
      end
      if (exp_w) begin
        checks++; if (bus.wdata !== 8'(32 + n)) begin errors++; $display("FAIL full_wdata c%0d got %h want %h", c, bus.wdata, 8'(32 + n)); end
      end
      hs = bus.req_valid[2] & bus.req_ready[2];
      @(posedge wclk); #1;
      if (hs) begin
        n++;
        set_data(2, 8'(32 + n));
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL full_count got %0d want 4", n); end
    bus.req_valid = '0;
    bus.wfull     = 1'b0;
  endtask

  task automatic test_early_release();
    do_reset();
    bus.req_valid = 4'b1001;
    set_data(0, 8'hA0);
    set_data(3, 8'hD0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) bus.req_valid = 4'b1000;
      @(negedge wclk);
      if (c == 1) begin
        checks++; if (bus.winc !== 1'b1 || bus.gnt_id !== 2'd0) begin errors++; $display("FAIL early_beat got winc %b id %0d want 1 0", bus.winc, bus.gnt_id); end
        checks++; if (bus.wdata !== 8'hA0) begin errors++; $display("FAIL early_wdata0 got %h want a0", bus.wdata); end
      end
      if (c == 2) begin
        checks++; if (bus.winc !== 1'b0 || bus.gnt_valid !== 1'b1) begin errors++; $display("FAIL early_drop got winc %b gv %b want 0 1", bus.winc, bus.gnt_valid); end
      end
      if (c == 3) begin
        checks++; if (bus.gnt_valid !== 1'b0 || bus.winc !== 1'b0) begin errors++; $display("FAIL early_arb got gv %b winc %b want 0 0", bus.gnt_valid, bus.winc); end
      end
      if (c == 4) begin
        checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 2'd3) begin errors++; $display("FAIL early_regrant got gv %b id %0d want 1 3", bus.gnt_valid, bus.gnt_id); end
        checks++; if (bus.winc !== 1'b1 || bus.wdata !== 8'hD0) begin errors++; $display("FAIL early_wdata3 got winc %b data %h want 1 d0", bus.winc, bus.wdata); end
      end
      @(posedge wclk); #1;
    end
    bus.req_valid = '0;
  endtask

  task automatic test_release_while_full();
    int pulses = 0;
    do_reset();
    bus.wfull     = 1'b1;
    bus.req_valid = 4'b0010;
    set_data(1, 8'h5A);
    for (int c = 0; c < 7; c++) begin
      if (c == 3) bus.req_valid = 4'b0000;
      if (c == 5) begin
        bus.wfull     = 1'b0;
        bus.req_valid = 4'b0010;
      end
      @(negedge wclk);
      if (c < 5 && bus.winc === 1'b1) pulses++;
      if (c == 1 || c == 2) begin
        checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 2'd1) begin errors++; $display("FAIL relfull_gnt c%0d got gv %b id %0d want 1 1", c, bus.gnt_valid, bus.gnt_id); end
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL relfull_ready c%0d got %b want 0000", c, bus.req_ready); end
      end
      if (c == 4) begin
        checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL relfull_arb got gv %b want 0", bus.gnt_valid); end
      end
      if (c == 6) begin
        checks++; if (bus.winc !== 1'b1 || bus.wdata !== 8'h5A) begin errors++; $display("FAIL relfull_resume got winc %b data %h want 1 5a", bus.winc, bus.wdata); end
      end
      @(posedge wclk); #1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL relfull_pulses got %0d want 0", pulses); end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req_valid = 4'b0100;
    set_data(2, 8'h77);
    set_data(0, 8'h11);
    @(negedge wclk); @(posedge wclk); #1;
    @(negedge wclk); @(posedge wclk); #1;
    @(negedge wclk);
    checks++; if (bus.winc !== 1'b1) begin errors++; $display("FAIL rstmid_beat2 got %b want 1", bus.winc); end
    #2;
    wrst_n = 1'b0;
    #1;
    checks++; if (bus.winc !== 1'b0) begin errors++; $display("FAIL rstmid_winc got %b want 0", bus.winc); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0000", bus.req_ready); end
    checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_gv got %b want 0", bus.gnt_valid); end
    checks++; if (bus.wdata !== 8'h00) begin errors++; $display("FAIL rstmid_wdata got %h want 00", bus.wdata); end
    @(posedge wclk); #1;
    wrst_n        = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge wclk);
    checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_arb got %b want 0", bus.gnt_valid); end
    @(posedge wclk); #1;
    @(negedge wclk);
    checks++; if (bus.gnt_valid !== 1'b1 || bus.gnt_id !== 2'd0) begin errors++; $display("FAIL rstmid_first got gv %b id %0d want 1 0", bus.gnt_valid, bus.gnt_id); end
    checks++; if (bus.wdata !== 8'h11) begin errors++; $display("FAIL rstmid_wdata0 got %h want 11", bus.wdata); end
    @(posedge wclk); #1;
    bus.req_valid = '0;
  endtask

  // Model: owner < 0 means the port is unowned (arbitration cycle).
  task automatic test_random();
    int owner = -1;
    int last  = int'(NREQ) - 1;
    int beats = 0;
    int hold_id = 0;
    int j;
    logic [NREQ-1:0]  hs = '0;
    logic [NREQ-1:0]  e_ready;
    logic [DSIZE-1:0] e_wdata;
    logic             e_winc, e_gv;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.req_valid[i]) begin
          if ($urandom_range(0, 7) == 0) bus.req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
          bus.req_valid[i] = 1'b1;
        end
        if (hs[i] || !bus.req_valid[i]) set_data(i, 8'($urandom));
      end
      bus.wfull = ($urandom_range(0, 3) == 0);
      if (owner < 0) begin
        e_winc = 1'b0; e_ready = '0; e_wdata = '0; e_gv = 1'b0;
      end else begin
        e_gv    = 1'b1;
        e_winc  = bus.req_valid[owner] && !bus.wfull;
        e_ready = bus.wfull ? '0 : 4'(1 << owner);
        e_wdata = bus.req_data[owner*DSIZE +: DSIZE];
      end
      @(negedge wclk);
      checks++; if (bus.winc !== e_winc) begin errors++; $display("FAIL rand_winc cyc%0d got %b want %b", cyc, bus.winc, e_winc); end
      checks++; if (bus.req_ready !== e_ready) begin errors++; $display("FAIL rand_ready cyc%0d got %b want %b", cyc, bus.req_ready, e_ready); end
      checks++; if (bus.wdata !== e_wdata) begin errors++; $display("FAIL rand_wdata cyc%0d got %h want %h", cyc, bus.wdata, e_wdata); end
      checks++; if (bus.gnt_valid !== e_gv) begin errors++; $display("FAIL rand_gv cyc%0d got %b want %b", cyc, bus.gnt_valid, e_gv); end
      checks++; if (bus.gnt_id !== 2'(hold_id)) begin errors++; $display("FAIL rand_gnt_id cyc%0d got %0d want %0d", cyc, bus.gnt_id, hold_id); end
      hs = bus.req_valid & bus.req_ready;
      if (owner < 0) begin
        for (int k = 1; k <= int'(NREQ); k++) begin
          j = (last + k) % int'(NREQ);
          if (owner < 0 && bus.req_valid[j]) begin
            owner = j; last = j; hold_id = j; beats = 0;
          end
        end
      end else if (!bus.req_valid[owner]) begin
        owner = -1;
      end else if (e_winc) begin
        beats++;
        if (beats == int'(MAXBURST)) owner = -1;
      end
      @(posedge wclk); #1;
    end
    bus.req_valid = '0;
    bus.wfull     = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;
    test_reset();
    test_single_stream();
    test_all_requesting();
    test_wfull_mid_burst();
    test_early_release();
    test_release_while_full();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wfifo_wr_arbiter.md
# wfifo_wr_arbiter

Write-side arbiter that shares the write port of the asynchronous FIFO between NREQ requesters in the write clock domain. It grants the port round-robin in bursts of up to MAXBURST words and muxes the granted requester's data onto wdata. It drives winc only when a transfer is accepted, and honours the registered wfull flag returned by the write-pointer/full logic. It sits between the write-domain producers and the FIFO's winc/wdata/wfull port.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DSIZE, 8: FIFO data width.
- MAXBURST, 4: maximum words per grant, 1..16.
- wclk  in  1  write-domain clock; all state on rising edge.
- wrst_n  in  1  asynchronous active-low reset. Asserts asynchronously and is released synchronously to wclk by the system.
- req_valid  in  NREQ  per-requester data valid.
- req_data  in  NREQ*DSIZE  packed data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready  out  NREQ  per-requester accept. At most one bit is high.
- wfull  in  1  FIFO full flag, registered in the wclk domain.
- winc  out  1  FIFO write strobe; one word per high cycle.
- wdata  out  DSIZE  FIFO write data. Equals the granted requester's data; 0 when no grant is active.
- gnt_valid  out  1  high while in BURST.
- gnt_id  out  clog2(NREQ)  index of the granted requester. Holds its last value when gnt_valid is low.

## Operation
- FSM has two states, ARB and BURST. Reset state is ARB.
- **ARB:**
  - If any req_valid bit is high, select the first requester with valid high, searching last_gnt+1, last_gnt+2, … modulo NREQ.
  - Register the selection into gnt_id and last_gnt, clear beat_cnt, and go to BURST.
  - If no request is present, stay in ARB.
  - No transfer occurs in ARB.
- **BURST:**
  - Transfer condition: xfer = req_valid[gnt_id] & ~wfull.
  - req_ready[gnt_id] = ~wfull; all other ready bits are 0.
  - winc = xfer. wdata = req_data slice of gnt_id.
  - beat_cnt increments on each xfer. Width is clog2(MAXBURST+1).
- **BURST exit (to ARB next cycle) on either condition:**
  - xfer with beat_cnt == MAXBURST-1, i.e. the MAXBURST-th beat; or
  - req_valid[gnt_id] low in any BURST cycle, regardless of wfull.
- **wfull high in BURST:** no transfer, grant is held, beat_cnt is held. A full FIFO never terminates a burst by itself.
- **Requester handshake:**
  - A word moves on a cycle where req_valid[i] & req_ready[i].
  - Requesters hold data stable while valid is high and ready is low.
  - Dropping valid ends that requester's burst.
- winc is gated by ~wfull combinationally. The FIFO's own winc & ~wfull gating is therefore redundant, and no write is ever attempted while full.
- **Reset values:** state ARB, last_gnt = NREQ-1 (requester 0 wins first), gnt_id 0, beat_cnt 0.
  - Outputs at reset: winc 0, req_ready 0, gnt_valid 0, wdata 0.
  - All outputs go to these values immediately on wrst_n assertion, including mid-burst.
  - A partially completed burst is abandoned with no replay.

## Timing
- Grant latency: req_valid seen in ARB at cycle N gives BURST at N+1, and the first possible transfer is at N+1.
- Throughput: 1 word/cycle within a burst when wfull is low.
- One ARB bubble cycle between consecutive bursts, including back-to-back bursts to the same requester.
- Sustained efficiency with continuous requests is MAXBURST/(MAXBURST+1).
- winc, req_ready and wdata are combinational from registered state, req_valid, req_data and wfull. No other input-to-output combinational paths exist.
- gnt_valid and gnt_id are registered.

## Test plan
- **Single requester, 6 words:** requester 1 streams 6 words 0x10..0x15 with wfull = 0.
  - winc high 4 cycles (0x10..0x13), low 1 cycle, high 2 cycles (0x14, 0x15).
  - gnt_id = 1 throughout.
- **All four requesting continuously after reset:** grant order is 0,1,2,3,0.
  - Each burst is 4 beats.
  - A single winc-low ARB cycle separates bursts.
  - 20 words are written in 24 cycles after the first grant.
- **wfull mid-burst:** wfull held high for 3 cycles after beat 2 of requester 2.
  - During those cycles: winc 0, req_ready 0, gnt_valid 1, gnt_id 2, beat_cnt 2.
  - Beats 3 and 4 complete after wfull falls, then ARB.
- **Early release:** requester 0 drops valid after 1 beat while requester 3 is waiting.
  - Next cycle is ARB.
  - The cycle after, gnt_id = 3 (round-robin from 0 skips idle 1 and 2).
- **Release while full:** wfull high at grant and the granted requester drops valid.
  - Return to ARB with zero winc pulses and beat_cnt unchanged.
- **Reset mid-burst:** assert wrst_n low at beat 2.
  - winc, req_ready and gnt_valid go 0 within the same cycle, without waiting for a clock edge.
  - After release with all requesters valid, requester 0 is granted first.
